// File: rtl/feat_stream_ctrl.sv
// Feature-map stream controller: walks a 12x12 map row-major and
// flags stride-2 2x2 windows as they land in the line buffer.
module feat_stream_ctrl #(
  parameter int DWIDTH = 16,
  parameter int FSIZE  = 12,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [AWIDTH-1:0] base_addr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              window_valid,
  output logic [2:0]        win_row,
  output logic [2:0]        win_col,
  output logic              busy,
  output logic              ack
);

  localparam int NPIX = FSIZE * FSIZE;
  localparam int KW   = $clog2(NPIX);
  localparam int CW   = $clog2(FSIZE);

  // The window taps are wired for a 14-stage buffer of DWIDTH-bit pixels.
  if (DWIDTH < 1 || FSIZE != 12) begin : g_bad_cfg
    $error("feat_stream_ctrl: unsupported DWIDTH/FSIZE");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [AWIDTH-1:0] base_q;
  logic [KW-1:0]     k;
  logic [KW-1:0]     k_nxt;
  logic [CW-1:0]     pr;
  logic [CW-1:0]     pc;
  logic              drn;
  logic              last_pix;
  logic              hit;
  logic [2:0]        hit_row;
  logic [2:0]        hit_col;
  logic              v1;
  logic [2:0]        r1;
  logic [2:0]        c1;

  assign k_nxt    = k + 1'b1;
  assign last_pix = (k == KW'(NPIX - 1));

  // Bottom-right pixel of a stride-2 window sits on an odd row and odd column.
  assign hit     = (state == READ) && pr[0] && pc[0];
  assign hit_row = 3'(pr >> 1);
  assign hit_col = 3'(pc >> 1);

  // Control FSM: address generation, drain timing and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      k         <= '0;
      pr        <= '0;
      pc        <= '0;
      drn       <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= READ;
            base_q    <= base_addr;
            k         <= '0;
            pr        <= '0;
            pc        <= '0;
            mem_addr  <= base_addr;
            mem_rd_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (last_pix) begin
            state     <= DRAIN;
            drn       <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
          end else begin
            k        <= k_nxt;
            mem_addr <= base_q + AWIDTH'(k_nxt);
            if (pc == CW'(FSIZE - 1)) begin
              pc <= '0;
              pr <= pr + 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        DRAIN: begin
          drn <= 1'b1;
          if (drn) begin
            state <= DONE;
            ack   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage window tag pipeline matching memory plus buffer latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= 1'b0;
      r1           <= '0;
      c1           <= '0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      v1           <= hit;
      r1           <= hit ? hit_row : 3'd0;
      c1           <= hit ? hit_col : 3'd0;
      window_valid <= v1;
      win_row      <= r1;
      win_col      <= c1;
    end
  end

endmodule

// File: tb/tb_feat_stream_ctrl.sv
// Directed bench for feat_stream_ctrl with a memory and
// 14-stage line buffer model fed by pixel index.
module tb_feat_stream_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          window_valid;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          busy;
  logic          ack;

  int checks = 0;
  int errors = 0;

  feat_stream_ctrl #(
    .DWIDTH(16),
    .FSIZE (12),
    .AWIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .base_addr   (base_addr),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .window_valid(window_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .ack         (ack)
  );

  always #5 clk = ~clk;

  // memory returns (addr - base) one cycle later; buffer shifts every cycle
  logic [AW-1:0] cur_base = '0;
  logic [AW-1:0] rdata = '0;
  logic [AW-1:0] lb [14];

  always @(posedge clk) begin
    rdata <= mem_rd_en ? mem_addr - cur_base : '0;
    lb[0] <= rdata;
    for (int i = 1; i < 14; i++) lb[i] <= lb[i-1];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_map(input logic [AW-1:0] base, input bit hold,
                         input int abort_at);
    int nv = 0;
    int first = -1;
    int last = -1;
    int nack = 0;
    int nrd = 0;
    int k;
    int f0;
    bit dead = 1'b0;
    bit ev;
    logic [2:0] er, ec;
    logic [AW-1:0] ea, t0, t1, t2, t3;
    cur_base  = base;
    base_addr = base;
    req       = 1'b1;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    base_addr = ~base;
    for (int c = 0; c <= 146; c++) begin
      k  = c - 2;
      ev = !dead && k >= 0 && k < 144 &&
           ((k / 12) % 2 == 1) && ((k % 12) % 2 == 1);
      if (dead) begin
        chk("abort_out", {mem_addr, mem_rd_en, window_valid, win_row,
                          win_col, busy, ack}, 64'd0);
      end else begin
        ea = base + AW'(c);
        chk("rd_en", mem_rd_en, 64'(c < 144));
        chk("addr", mem_addr, c < 144 ? 64'(ea) : 64'd0);
        chk("busy", busy, 64'd1);
        chk("ack", ack, 64'(c == 146));
        chk("wvalid", window_valid, 64'(ev));
        if (ev) begin
          er = 3'((k / 12) / 2);
          ec = 3'((k % 12) / 2);
          chk("win_rc", {win_row, win_col}, {er, ec});
          f0 = 24 * int'(er) + 2 * int'(ec);
          t0 = AW'(f0);
          t1 = AW'(f0 + 1);
          t2 = AW'(f0 + 12);
          t3 = AW'(f0 + 13);
          chk("feat", {lb[13], lb[12], lb[1], lb[0]}, {t0, t1, t2, t3});
        end
      end
      if (window_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      nack += int'(ack);
      nrd  += int'(mem_rd_en);
      if (hold && c == 145) req = 1'b0;
      if (c == abort_at) rst = 1'b1;
      @(posedge clk); #1;
      if (c == abort_at) begin
        rst  = 1'b0;
        dead = 1'b1;
      end
    end
    if (abort_at < 0) begin
      chk("n_windows", nv, 36);
      chk("first_win", first, 15);
      chk("last_win", last, 145);
      chk("n_ack", nack, 1);
      chk("n_rd", nrd, 144);
    end else begin
      chk("abort_ack", nack, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {mem_addr, mem_rd_en, window_valid, win_row, win_col,
                    busy, ack}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_noreq", {busy, mem_rd_en}, 64'd0);

    run_map(10'h040, 1'b0, -1);
    run_map(10'h040, 1'b0, -1);
    run_map(10'h3F0, 1'b0, -1);
    run_map(10'h100, 1'b1, -1);
    chk("no_rerun0", {busy, mem_rd_en}, 64'd0);
    @(posedge clk); #1;
    chk("no_rerun1", {busy, mem_rd_en}, 64'd0);
    run_map(10'h200, 1'b0, 50);
    run_map(10'h040, 1'b0, -1);
    chk("end_idle", {busy, ack, window_valid, win_row, win_col}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
